// File: rtl/cordic.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// cordic
// Iterative CORDIC engine on signed Q16.16 operands. One micro-rotation is
// performed per clock in either the circular or the linear coordinate system,
// in rotation mode (drive z toward 0) or vectoring mode (drive y toward 0).
// Circular gain K is not compensated; callers pre-scale their operands.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous, active-high reset
//   enable       start strobe, only honoured while idle
//   mode_op      0 = rotation, 1 = vectoring
//   mode_coord   2'b01 = circular, 2'b00 = linear, others = pass-through
//   x_in/y_in/z_in     signed Q16.16 operands, latched on start
//   x_out/y_out/z_out  signed Q16.16 results, held until the next result
//   valid        one-cycle pulse marking new results
// ---------------------------------------------------------------------------
module cordic #(
  parameter int WIDTH      = 32,
  parameter int ITERATIONS = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    mode_op,
  input  logic [1:0]              mode_coord,
  input  logic signed [WIDTH-1:0] x_in,
  input  logic signed [WIDTH-1:0] y_in,
  input  logic signed [WIDTH-1:0] z_in,
  output logic signed [WIDTH-1:0] x_out,
  output logic signed [WIDTH-1:0] y_out,
  output logic signed [WIDTH-1:0] z_out,
  output logic                    valid
);

  localparam int CW = $clog2(ITERATIONS + 1);
  localparam logic [1:0] COORD_LIN  = 2'b00;
  localparam logic [1:0] COORD_CIRC = 2'b01;
  // pi/2 in Q16.16
  localparam logic signed [WIDTH-1:0] HALF_PI = WIDTH'(102944);

  typedef enum logic [1:0] {
    IDLE,
    PREP,
    ITER,
    DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           iter_q, iter_d;
  logic                    mode_op_q, mode_op_d;
  logic [1:0]              mode_coord_q, mode_coord_d;
  logic signed [WIDTH-1:0] x_q, x_d;
  logic signed [WIDTH-1:0] y_q, y_d;
  logic signed [WIDTH-1:0] z_q, z_d;
  logic signed [WIDTH-1:0] x_out_q, x_out_d;
  logic signed [WIDTH-1:0] y_out_q, y_out_d;
  logic signed [WIDTH-1:0] z_out_q, z_out_d;
  logic                    valid_q, valid_d;

  logic signed [WIDTH-1:0] x_shift;
  logic signed [WIDTH-1:0] y_shift;
  logic signed [WIDTH-1:0] e_i;
  logic                    dir_pos;
  logic                    is_circ;
  logic                    is_lin;

  // Elementary angles round(atan(2^-i) * 65536).
  function automatic logic signed [WIDTH-1:0] atan_lut(input int idx);
    logic signed [WIDTH-1:0] val;
    case (idx)
      0:       val = WIDTH'(51472);
      1:       val = WIDTH'(30386);
      2:       val = WIDTH'(16055);
      3:       val = WIDTH'(8150);
      4:       val = WIDTH'(4091);
      5:       val = WIDTH'(2047);
      6:       val = WIDTH'(1024);
      7:       val = WIDTH'(512);
      8:       val = WIDTH'(256);
      9:       val = WIDTH'(128);
      10:      val = WIDTH'(64);
      11:      val = WIDTH'(32);
      12:      val = WIDTH'(16);
      13:      val = WIDTH'(8);
      14:      val = WIDTH'(4);
      15:      val = WIDTH'(2);
      default: val = '0;
    endcase
    return val;
  endfunction

  // Linear-system step sizes 2^-i in Q16.16.
  function automatic logic signed [WIDTH-1:0] lin_lut(input int idx);
    logic signed [WIDTH-1:0] one;
    one = WIDTH'(65536);
    return one >>> idx;
  endfunction

  // Arithmetic shifts keep the sign of negative operands.
  assign x_shift = x_q >>> iter_q;
  assign y_shift = y_q >>> iter_q;
  assign is_circ = (mode_coord_q == COORD_CIRC);
  assign is_lin  = (mode_coord_q == COORD_LIN);
  assign e_i     = is_circ ? atan_lut(int'(iter_q)) : lin_lut(int'(iter_q));

  // Rotation steers on the sign of z, vectoring on the sign of y.
  assign dir_pos = mode_op_q ? y_q[WIDTH-1] : ~z_q[WIDTH-1];

  // Next-state and datapath logic. Every register holds by default; valid
  // only rises in the DONE state. Reserved coordinate codes skip both the
  // quadrant fix-up and the micro-rotations, so the operands come out as-is.
  always_comb begin
    state_d      = state_q;
    iter_d       = iter_q;
    mode_op_d    = mode_op_q;
    mode_coord_d = mode_coord_q;
    x_d          = x_q;
    y_d          = y_q;
    z_d          = z_q;
    x_out_d      = x_out_q;
    y_out_d      = y_out_q;
    z_out_d      = z_out_q;
    valid_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (enable) begin
          mode_op_d    = mode_op;
          mode_coord_d = mode_coord;
          x_d          = x_in;
          y_d          = y_in;
          z_d          = z_in;
          iter_d       = '0;
          state_d      = PREP;
        end
      end

      PREP: begin
        // Quarter-turn pre-rotation extends circular convergence to +/-pi.
        if (is_circ) begin
          if (!mode_op_q) begin
            if (z_q > HALF_PI) begin
              x_d = -y_q;
              y_d = x_q;
              z_d = z_q - HALF_PI;
            end else if (z_q < -HALF_PI) begin
              x_d = y_q;
              y_d = -x_q;
              z_d = z_q + HALF_PI;
            end
          end else if (x_q[WIDTH-1]) begin
            if (!y_q[WIDTH-1]) begin
              x_d = y_q;
              y_d = -x_q;
              z_d = z_q + HALF_PI;
            end else begin
              x_d = -y_q;
              y_d = x_q;
              z_d = z_q - HALF_PI;
            end
          end
        end
        iter_d  = '0;
        state_d = ITER;
      end

      ITER: begin
        if (is_circ || is_lin) begin
          if (dir_pos) begin
            y_d = y_q + x_shift;
            z_d = z_q - e_i;
            if (is_circ) begin
              x_d = x_q - y_shift;
            end
          end else begin
            y_d = y_q - x_shift;
            z_d = z_q + e_i;
            if (is_circ) begin
              x_d = x_q + y_shift;
            end
          end
        end
        if (iter_q == CW'(ITERATIONS - 1)) begin
          state_d = DONE;
        end else begin
          iter_d = iter_q + CW'(1);
        end
      end

      DONE: begin
        x_out_d = x_q;
        y_out_d = y_q;
        z_out_d = z_q;
        valid_d = 1'b1;
        iter_d  = '0;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any computation in flight
  // and clears the visible results.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      iter_q       <= '0;
      mode_op_q    <= 1'b0;
      mode_coord_q <= 2'b00;
      x_q          <= '0;
      y_q          <= '0;
      z_q          <= '0;
      x_out_q      <= '0;
      y_out_q      <= '0;
      z_out_q      <= '0;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      iter_q       <= iter_d;
      mode_op_q    <= mode_op_d;
      mode_coord_q <= mode_coord_d;
      x_q          <= x_d;
      y_q          <= y_d;
      z_q          <= z_d;
      x_out_q      <= x_out_d;
      y_out_q      <= y_out_d;
      z_out_q      <= z_out_d;
      valid_q      <= valid_d;
    end
  end

  assign x_out = x_out_q;
  assign y_out = y_out_q;
  assign z_out = z_out_q;
  assign valid = valid_q;

endmodule

// File: tb/tb_cordic.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_cordic
// Directed bench for the cordic engine. Each started operation pushes its
// ideal result (computed with real-valued math) onto a scoreboard queue; the
// entry is popped and compared when valid pulses.
// ---------------------------------------------------------------------------
module tb_cordic;

  localparam int  WIDTH      = 32;
  localparam int  ITERATIONS = 16;
  localparam int  LAT        = ITERATIONS + 2;
  localparam int  TOL        = 200;
  localparam real PI         = 3.14159265358979;

  logic                    clk;
  logic                    rst;
  logic                    enable;
  logic                    mode_op;
  logic [1:0]              mode_coord;
  logic signed [WIDTH-1:0] x_in;
  logic signed [WIDTH-1:0] y_in;
  logic signed [WIDTH-1:0] z_in;
  logic signed [WIDTH-1:0] x_out;
  logic signed [WIDTH-1:0] y_out;
  logic signed [WIDTH-1:0] z_out;
  logic                    valid;

  typedef struct {
    string             tag;
    logic signed [31:0] ex;
    logic signed [31:0] ey;
    logic signed [31:0] ez;
    int                tx;
    int                ty;
    int                tz;
  } exp_t;

  exp_t sbQueue[$];
  int   testsRun    = 0;
  int   testsFailed = 0;
  int   edgeCount   = 0;
  int   startEdge   = 0;
  real  gainK;

  cordic #(
    .WIDTH(WIDTH),
    .ITERATIONS(ITERATIONS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .mode_op(mode_op),
    .mode_coord(mode_coord),
    .x_in(x_in),
    .y_in(y_in),
    .z_in(z_in),
    .x_out(x_out),
    .y_out(y_out),
    .z_out(z_out),
    .valid(valid)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Edge counter used to measure start-to-valid latency.
  always @(posedge clk) begin
    edgeCount <= edgeCount + 1;
  end

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic signed [31:0] toFix(input real r);
    real v;
    v = r * 65536.0;
    return 32'($rtoi(v >= 0.0 ? v + 0.5 : v - 0.5));
  endfunction

  function automatic real toReal(input logic signed [31:0] v);
    return $itor(v) / 65536.0;
  endfunction

  // Exact comparison.
  task automatic checkExact(input string tag, input logic signed [31:0] obs,
                            input logic signed [31:0] expv);
    testsRun++;
    assert (obs === expv)
    else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Comparison within +/-tol LSB using wrapped 32-bit difference.
  task automatic checkNear(input string tag, input logic signed [31:0] obs,
                           input logic signed [31:0] expv, input int tol);
    logic signed [31:0] diff;
    logic               ok;
    diff = obs - expv;
    ok   = (diff <= tol) && (diff >= -tol);
    testsRun++;
    assert (ok === 1'b1)
    else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %0d expected %0d (+/-%0d)", tag, obs, expv, tol);
    end
  endtask

  // Drives one start pulse; optionally pushes the ideal result.
  task automatic applyStimulus(input string tag, input logic op, input logic [1:0] coord,
                               input logic signed [31:0] xi, input logic signed [31:0] yi,
                               input logic signed [31:0] zi, input bit push);
    exp_t e;
    real  xr, yr, zr;
    xr    = toReal(xi);
    yr    = toReal(yi);
    zr    = toReal(zi);
    e.tag = tag;
    if (coord == 2'b01 && !op) begin
      e.ex = toFix(gainK * (xr * $cos(zr) - yr * $sin(zr)));
      e.ey = toFix(gainK * (yr * $cos(zr) + xr * $sin(zr)));
      e.ez = 32'sd0;
      e.tx = TOL; e.ty = TOL; e.tz = TOL;
    end else if (coord == 2'b01) begin
      e.ex = toFix(gainK * $sqrt(xr * xr + yr * yr));
      e.ey = 32'sd0;
      e.ez = toFix(zr + $atan2(yr, xr));
      e.tx = TOL; e.ty = TOL; e.tz = TOL;
    end else if (coord == 2'b00 && !op) begin
      e.ex = xi;
      e.ey = toFix(yr + xr * zr);
      e.ez = 32'sd0;
      e.tx = 0; e.ty = TOL; e.tz = TOL;
    end else if (coord == 2'b00) begin
      e.ex = xi;
      e.ey = 32'sd0;
      e.ez = toFix(zr + yr / xr);
      e.tx = 0; e.ty = TOL; e.tz = TOL;
    end else begin
      e.ex = xi;
      e.ey = yi;
      e.ez = zi;
      e.tx = 0; e.ty = 0; e.tz = 0;
    end
    if (push) sbQueue.push_back(e);
    @(negedge clk);
    mode_op    = op;
    mode_coord = coord;
    x_in       = xi;
    y_in       = yi;
    z_in       = zi;
    enable     = 1'b1;
    @(posedge clk);
    #1;
    enable    = 1'b0;
    startEdge = edgeCount;
  endtask

  // Pops the oldest expectation and compares it to the outputs.
  task automatic checkOutput(input string tag);
    exp_t e;
    if (sbQueue.size() == 0) begin
      checkExact({tag, " scoreboard"}, 32'(sbQueue.size()), 32'sd1);
    end else begin
      e = sbQueue.pop_front();
      checkNear({e.tag, " x_out"}, x_out, e.ex, e.tx);
      checkNear({e.tag, " y_out"}, y_out, e.ey, e.ty);
      checkNear({e.tag, " z_out"}, z_out, e.ez, e.tz);
    end
  endtask

  // Bounded wait for valid, then latency, result and pulse-width checks.
  task automatic waitForValid(input string tag);
    int n;
    bit seen;
    n    = 0;
    seen = 1'b0;
    while (n < LAT + 10 && !seen) begin
      @(posedge clk);
      #1;
      n++;
      if (valid === 1'b1) seen = 1'b1;
    end
    checkExact({tag, " valid seen"}, {31'b0, seen}, 32'sd1);
    checkExact({tag, " latency"}, edgeCount - startEdge, LAT);
    if (seen) checkOutput(tag);
    @(posedge clk);
    #1;
    checkExact({tag, " valid width"}, {31'b0, valid}, 32'sd0);
  endtask

  // Counts valid pulses over a window of cycles.
  task automatic countValids(input int cycles, output int cnt);
    cnt = 0;
    for (int k = 0; k < cycles; k++) begin
      @(posedge clk);
      #1;
      if (valid === 1'b1) cnt++;
    end
  endtask

  initial begin
    int   extra;
    real  p;
    rst        = 1'b1;
    enable     = 1'b0;
    mode_op    = 1'b0;
    mode_coord = 2'b00;
    x_in       = '0;
    y_in       = '0;
    z_in       = '0;

    gainK = 1.0;
    p     = 1.0;
    for (int i = 0; i < ITERATIONS; i++) begin
      gainK = gainK * $sqrt(1.0 + p);
      p     = p / 4.0;
    end

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    checkExact("reset x_out", x_out, 32'sd0);
    checkExact("reset y_out", y_out, 32'sd0);
    checkExact("reset z_out", z_out, 32'sd0);
    checkExact("reset valid", {31'b0, valid}, 32'sd0);
    @(negedge clk);
    rst = 1'b0;

    // Circular rotation, 30 degrees and a quadrant sweep
    applyStimulus("rot30", 1'b0, 2'b01, 32'sd39796, 32'sd0, 32'sd34314, 1'b1);
    waitForValid("rot30");
    applyStimulus("rot135", 1'b0, 2'b01, 32'sd39796, 32'sd0, toFix(135.0 * PI / 180.0), 1'b1);
    waitForValid("rot135");
    applyStimulus("rotm90", 1'b0, 2'b01, 32'sd39796, 32'sd0, toFix(-90.0 * PI / 180.0), 1'b1);
    waitForValid("rotm90");
    applyStimulus("rot180", 1'b0, 2'b01, 32'sd39796, 32'sd0, toFix(PI), 1'b1);
    waitForValid("rot180");
    applyStimulus("rotm179", 1'b0, 2'b01, 32'sd39796, 32'sd0, toFix(-179.0 * PI / 180.0), 1'b1);
    waitForValid("rotm179");

    // Linear rotation (multiply-accumulate)
    applyStimulus("lin0", 1'b0, 2'b00, 32'sd32768, 32'sd0, 32'sd98304, 1'b1);
    waitForValid("lin0");
    applyStimulus("lin1", 1'b0, 2'b00, 32'sd131072, 32'sd0, -32'sd98304, 1'b1);
    waitForValid("lin1");
    applyStimulus("lin2", 1'b0, 2'b00, -32'sd32768, 32'sd0, 32'sd65536, 1'b1);
    waitForValid("lin2");
    applyStimulus("lin3", 1'b0, 2'b00, 32'sd6554, 32'sd0, 32'sd6554, 1'b1);
    waitForValid("lin3");

    // Vectoring: magnitude/atan and divide
    applyStimulus("cvec", 1'b1, 2'b01, 32'sd65536, 32'sd65536, 32'sd0, 1'b1);
    waitForValid("cvec");
    applyStimulus("lvec", 1'b1, 2'b00, 32'sd131072, 32'sd65536, 32'sd0, 1'b1);
    waitForValid("lvec");

    // Reserved coordinate codes echo the operands
    applyStimulus("res10", 1'b0, 2'b10, 32'sd123456, -32'sd7890, 32'sd55555, 1'b1);
    waitForValid("res10");
    applyStimulus("res11", 1'b1, 2'b11, -32'sd4242, 32'sd99999, -32'sd31415, 1'b1);
    waitForValid("res11");

    // Enable pulsed mid-computation is ignored
    applyStimulus("ign", 1'b0, 2'b01, 32'sd39796, 32'sd0, -32'sd34314, 1'b1);
    repeat (4) @(posedge clk);
    @(negedge clk);
    mode_op    = 1'b1;
    mode_coord = 2'b00;
    x_in       = 32'sd1000;
    y_in       = 32'sd2000;
    z_in       = 32'sd3000;
    enable     = 1'b1;
    @(posedge clk);
    #1;
    enable = 1'b0;
    waitForValid("ign");
    countValids(LAT + 4, extra);
    checkExact("ign extra valid", extra, 32'sd0);

    // Reset mid-computation aborts without a valid pulse
    applyStimulus("abort", 1'b0, 2'b01, 32'sd39796, 32'sd0, 32'sd34314, 1'b0);
    repeat (6) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkExact("abort x_out", x_out, 32'sd0);
    checkExact("abort y_out", y_out, 32'sd0);
    checkExact("abort z_out", z_out, 32'sd0);
    checkExact("abort valid", {31'b0, valid}, 32'sd0);
    @(negedge clk);
    rst = 1'b0;
    countValids(LAT + 6, extra);
    checkExact("abort no valid", extra, 32'sd0);

    // Recovery after reset
    applyStimulus("recover", 1'b0, 2'b01, 32'sd39796, 32'sd0, 32'sd34314, 1'b1);
    waitForValid("recover");

    checkExact("scoreboard drained", 32'(sbQueue.size()), 32'sd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
